// File: rtl/clk_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module   : clk_gen_pkg
// Brief    : Shared constants and channel state encoding for clk_enable_gen
// Revision : 1.0 - initial release
// ============================================================================
package clk_gen_pkg;

    localparam int DIV_W_DEF        = 16;
    localparam int DEFAULT_DIV_DEF  = 9;
    localparam int LOCK_SYNC_STAGES = 2;

    // Channel run state: idle holds the counter cleared, run divides.
    typedef enum logic [0:0] {
        CH_IDLE = 1'b0,
        CH_RUN  = 1'b1
    } chan_state_e;

endpackage : clk_gen_pkg
`default_nettype wire

// File: rtl/clk_div_chan.sv
`default_nettype none
// ============================================================================
// Module   : clk_div_chan
// Brief    : One clock-enable channel: counter, shadow/working divisor,
//            start/stop/sync handling, tick and 50 % toggle outputs
// Revision : 1.0 - initial release
// ============================================================================
module clk_div_chan
    import clk_gen_pkg::*;
#(
    parameter int DIV_W       = DIV_W_DEF,
    parameter int DEFAULT_DIV = DEFAULT_DIV_DEF
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             lock_i,
    input  logic             en_i,
    input  logic             load_i,
    input  logic [DIV_W-1:0] div_i,
    input  logic             sync_i,
    output logic             tick_o,
    output logic             clk_o,
    output logic             active_o
);

    chan_state_e      state_q, state_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] shadow_q, shadow_d;
    logic [DIV_W-1:0] work_q, work_d;
    logic             tick_q, tick_d;
    logic             clk_q, clk_d;

    // Terminal count; a zero divisor behaves as divide-by-one.
    logic [DIV_W-1:0] term_cnt;
    logic             wrap;

    assign term_cnt = (work_q == '0) ? '0 : (work_q - DIV_W'(1));
    assign wrap     = (cnt_q == term_cnt);

    // Next-state logic: lock loss overrides sync, sync overrides start/stop/wrap.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        work_d   = work_q;
        clk_d    = clk_q;
        tick_d   = 1'b0;
        shadow_d = load_i ? div_i : shadow_q;

        if (!lock_i) begin
            // Working divisor survives so the channel restarts at its old rate.
            state_d = CH_IDLE;
            cnt_d   = '0;
            clk_d   = 1'b0;
        end else begin
            case (state_q)
                CH_IDLE: begin
                    // Inactive channels track the shadow immediately.
                    work_d = shadow_q;
                    cnt_d  = '0;
                    clk_d  = 1'b0;
                    if (en_i) begin
                        state_d = CH_RUN;
                    end
                end
                CH_RUN: begin
                    if (sync_i) begin
                        cnt_d = '0;
                        clk_d = 1'b0;
                    end else if (wrap) begin
                        tick_d = 1'b1;
                        cnt_d  = '0;
                        work_d = shadow_q;
                        if (!en_i) begin
                            // Stop only on a tick and always leave clk_o low,
                            // so no runt pulse and no stuck-high output.
                            state_d = CH_IDLE;
                            clk_d   = 1'b0;
                        end else begin
                            clk_d = ~clk_q;
                        end
                    end else begin
                        cnt_d = cnt_q + DIV_W'(1);
                    end
                end
                default: begin
                    state_d = CH_IDLE;
                    cnt_d   = '0;
                    clk_d   = 1'b0;
                end
            endcase
        end
    end

    // Channel state register with asynchronous clear to the reset divisor.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= CH_IDLE;
            cnt_q    <= '0;
            shadow_q <= DIV_W'(DEFAULT_DIV);
            work_q   <= DIV_W'(DEFAULT_DIV);
            tick_q   <= 1'b0;
            clk_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            work_q   <= work_d;
            tick_q   <= tick_d;
            clk_q    <= clk_d;
        end
    end

    assign tick_o   = tick_q;
    assign clk_o    = clk_q;
    assign active_o = (state_q == CH_RUN);

endmodule : clk_div_chan
`default_nettype wire

// File: rtl/clk_enable_gen.sv
`default_nettype none
// ============================================================================
// Module   : clk_enable_gen
// Brief    : Multi-channel clock-enable generator gated by a synchronised
//            MMCM lock; one clk_div_chan per channel
// Revision : 1.0 - initial release
// ============================================================================
module clk_enable_gen
    import clk_gen_pkg::*;
#(
    parameter int N_CH        = 2,
    parameter int DIV_W       = DIV_W_DEF,
    parameter int DEFAULT_DIV = DEFAULT_DIV_DEF
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  locked_i,
    input  logic [N_CH-1:0]       en_i,
    input  logic [N_CH-1:0]       load_i,
    input  logic [N_CH*DIV_W-1:0] div_i,
    input  logic                  sync_i,
    output logic [N_CH-1:0]       tick_o,
    output logic [N_CH-1:0]       clk_o,
    output logic [N_CH-1:0]       active_o
);

    logic [LOCK_SYNC_STAGES-1:0] lock_sync_q, lock_sync_d;
    logic                        lock_s;

    // Shift the asynchronous lock input through the synchroniser chain.
    always_comb begin
        lock_sync_d = {lock_sync_q[LOCK_SYNC_STAGES-2:0], locked_i};
    end

    // Lock synchroniser flops.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lock_sync_q <= '0;
        end else begin
            lock_sync_q <= lock_sync_d;
        end
    end

    assign lock_s = lock_sync_q[LOCK_SYNC_STAGES-1];

    for (genvar k = 0; k < N_CH; k++) begin : g_chan
        clk_div_chan #(
            .DIV_W       (DIV_W),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_chan (
            .clk_i    (clk_i),
            .rst_i    (rst_i),
            .lock_i   (lock_s),
            .en_i     (en_i[k]),
            .load_i   (load_i[k]),
            .div_i    (div_i[k*DIV_W +: DIV_W]),
            .sync_i   (sync_i),
            .tick_o   (tick_o[k]),
            .clk_o    (clk_o[k]),
            .active_o (active_o[k])
        );
    end

endmodule : clk_enable_gen
`default_nettype wire

// File: tb/tb_clk_enable_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_clk_enable_gen
// Brief    : Scoreboard bench for clk_enable_gen (2 channels, 16-bit divisor)
// Revision : 1.0 - initial release
// ============================================================================
module tb_clk_enable_gen;

    logic        clk;
    logic        rst;
    logic        locked;
    logic [1:0]  en;
    logic [1:0]  load;
    logic [31:0] div;
    logic        sync;
    logic [1:0]  tick_o;
    logic [1:0]  clk_o;
    logic [1:0]  active_o;

    clk_enable_gen #(
        .N_CH        (2),
        .DIV_W       (16),
        .DEFAULT_DIV (9)
    ) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .locked_i (locked),
        .en_i     (en),
        .load_i   (load),
        .div_i    (div),
        .sync_i   (sync),
        .tick_o   (tick_o),
        .clk_o    (clk_o),
        .active_o (active_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Edge counter: during the low phase cyc equals the number of rising edges so far.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [31:0] cyc;
        logic        clk;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    logic exp_clk_st [2];
    int   checks = 0;
    int   errors = 0;

    function automatic int q_size(input int ch);
        return (ch == 0) ? q0.size() : q1.size();
    endfunction

    function automatic exp_t q_front(input int ch);
        return (ch == 0) ? q0[0] : q1[0];
    endfunction

    task automatic q_pop(input int ch);
        if (ch == 0) void'(q0.pop_front());
        else         void'(q1.pop_front());
    endtask

    // Expected tick at edge c; clk_o toggles with it.
    task automatic push(input int ch, input int c);
        exp_t e;
        exp_clk_st[ch] = ~exp_clk_st[ch];
        e.cyc = c;
        e.clk = exp_clk_st[ch];
        if (ch == 0) q0.push_back(e);
        else         q1.push_back(e);
    endtask

    // Expected final tick before the channel stops; clk_o ends low.
    task automatic push_stop(input int ch, input int c);
        exp_t e;
        exp_clk_st[ch] = 1'b0;
        e.cyc = c;
        e.clk = 1'b0;
        if (ch == 0) q0.push_back(e);
        else         q1.push_back(e);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic mon_chan(input int ch);
        exp_t e;
        while (q_size(ch) > 0 && int'(q_front(ch).cyc) < cyc) begin
            e = q_front(ch);
            checks++;
            errors++;
            $display("FAIL missing_tick ch%0d: got none expected tick at cycle %0d", ch, e.cyc);
            q_pop(ch);
        end
        if (tick_o[ch]) begin
            checks++;
            if (q_size(ch) == 0 || int'(q_front(ch).cyc) != cyc) begin
                errors++;
                $display("FAIL unexpected_tick ch%0d: got tick at cycle %0d expected none", ch, cyc);
            end else begin
                e = q_front(ch);
                q_pop(ch);
                checks++;
                if (clk_o[ch] !== e.clk) begin
                    errors++;
                    $display("FAIL tick_clk ch%0d: got clk_o=%0b expected %0b (cycle %0d)",
                             ch, clk_o[ch], e.clk, cyc);
                end
            end
        end
    endtask

    // Monitor: compare every presented tick against the scoreboard.
    always @(negedge clk) begin
        mon_chan(0);
        mon_chan(1);
    end

    task automatic wait_to(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

    int a_st, p_st, s_st, e_st, r2, hi;

    initial begin
        rst = 1'b1; locked = 1'b1; en = 2'b11; load = 2'b00; div = '0; sync = 1'b0;
        exp_clk_st[0] = 1'b0;
        exp_clk_st[1] = 1'b0;

        // Reset state and default divisor 9.
        wait_to(3);
        chk("rst_tick", 32'(tick_o), 0);
        chk("rst_clk", 32'(clk_o), 0);
        chk("rst_active", 32'(active_o), 0);
        wait_to(4);
        rst = 1'b0;
        a_st = 7;
        for (int k = 1; k <= 5; k++) push(0, a_st + 9 * k);
        push_stop(0, a_st + 54);
        for (int k = 1; k <= 4; k++) push(1, a_st + 9 * k);
        push_stop(1, a_st + 45);
        wait_to(a_st - 1); chk("start_pre", 32'(active_o), 0);
        wait_to(a_st);     chk("start_act", 32'(active_o), 3);
        hi = 0;
        for (int c = a_st + 1; c <= a_st + 36; c++) begin
            wait_to(c);
            hi += int'(clk_o[0]);
        end
        chk("duty_hi", 32'(hi), 18);

        // Stop with clk_o low (ch1), cancelled stop then stop with clk_o high (ch0).
        wait_to(a_st + 37); en[1] = 1'b0;
        wait_to(a_st + 38); en[0] = 1'b0;
        wait_to(a_st + 42); en[0] = 1'b1;
        wait_to(a_st + 44); chk("stop_pre", 32'(active_o), 3);
        wait_to(a_st + 45); chk("stop_ch1", 32'(active_o), 1);
        wait_to(a_st + 47); en[0] = 1'b0;
        wait_to(a_st + 53); chk("stop_ch0_pre", 32'(active_o), 1);
        wait_to(a_st + 54); chk("stop_ch0", 32'(active_o), 0);
        wait_to(a_st + 74);
        chk("stop_clk_low", 32'(clk_o), 0);
        chk("stop_idle", 32'(active_o), 0);

        // D=4 / D=7 concurrently, then mid-period loads on ch1 (5, 0, 7).
        p_st = a_st + 80;
        wait_to(p_st);
        s_st = p_st + 4;
        exp_clk_st[0] = 1'b0;
        exp_clk_st[1] = 1'b0;
        for (int k = 1; k <= 36; k++) push(0, s_st + 4 * k);
        for (int k = 1; k <= 14; k++) push(1, s_st + 7 * k);
        push(1, s_st + 105); push(1, s_st + 110); push(1, s_st + 115);
        for (int c = 116; c <= 122; c++) push(1, s_st + c);
        push(1, s_st + 129); push(1, s_st + 136); push(1, s_st + 143);
        load = 2'b11; div = {16'd7, 16'd4};
        wait_to(p_st + 1); load = 2'b00;
        wait_to(p_st + 3); chk("run2_pre", 32'(active_o), 0); en = 2'b11;
        wait_to(s_st);     chk("run2_act", 32'(active_o), 3);
        wait_to(s_st + 101); load = 2'b10; div[31:16] = 16'd5;
        wait_to(s_st + 102); load = 2'b00;
        wait_to(s_st + 111); load = 2'b10; div[31:16] = 16'd0;
        wait_to(s_st + 112); load = 2'b00;
        wait_to(s_st + 120); load = 2'b10; div[31:16] = 16'd7;
        wait_to(s_st + 121); load = 2'b00;

        // Sync lands on an edge where ch0 would tick.
        wait_to(s_st + 147); sync = 1'b1;
        e_st = s_st + 148;
        wait_to(e_st); sync = 1'b0;
        chk("sync_tick", 32'(tick_o), 0);
        chk("sync_clk", 32'(clk_o), 0);
        chk("sync_act", 32'(active_o), 3);
        exp_clk_st[0] = 1'b0;
        exp_clk_st[1] = 1'b0;
        for (int k = 1; k <= 8; k++) push(0, e_st + 4 * k);
        for (int k = 1; k <= 4; k++) push(1, e_st + 7 * k);
        wait_to(e_st + 28); chk("lcm_tick", 32'(tick_o), 3);

        // Lock loss, then restart with preserved divisors.
        wait_to(e_st + 30); locked = 1'b0;
        wait_to(e_st + 32); chk("unlock_pre", 32'(active_o), 3);
        wait_to(e_st + 33);
        chk("unlock_tick", 32'(tick_o), 0);
        chk("unlock_clk", 32'(clk_o), 0);
        chk("unlock_act", 32'(active_o), 0);
        wait_to(e_st + 40); locked = 1'b1;
        exp_clk_st[0] = 1'b0;
        exp_clk_st[1] = 1'b0;
        for (int k = 1; k <= 5; k++) push(0, e_st + 43 + 4 * k);
        for (int k = 1; k <= 3; k++) push(1, e_st + 43 + 7 * k);
        wait_to(e_st + 42); chk("relock_pre", 32'(active_o), 0);
        wait_to(e_st + 43); chk("relock_act", 32'(active_o), 3);

        // Asynchronous reset mid-period, then default divisor again.
        wait_to(e_st + 66);
        chk("pre_rst_clk", 32'(clk_o), 3);
        rst = 1'b1;
        #1;
        chk("async_rst_clk", 32'(clk_o), 0);
        chk("async_rst_act", 32'(active_o), 0);
        wait_to(e_st + 68);
        rst = 1'b0;
        r2 = e_st + 68;
        exp_clk_st[0] = 1'b0;
        exp_clk_st[1] = 1'b0;
        push(0, r2 + 12);
        push(1, r2 + 12);
        wait_to(r2 + 3);  chk("rst2_act", 32'(active_o), 3);
        wait_to(r2 + 20);
        chk("drain_ch0", 32'(q0.size()), 0);
        chk("drain_ch1", 32'(q1.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_clk_enable_gen
`default_nettype wire
